// File: rtl/reg_write_scheduler_pkg.sv
// Shared definitions for the register write scheduler: register map, FSM states and grant sources.
// Holds no logic; it is imported by the top module.
package reg_write_scheduler_pkg;

    localparam int NUM_REGS = 5;

    localparam int REG_EN_OUT_LO  = 0;
    localparam int REG_EN_OUT_HI  = 1;
    localparam int REG_EN_PWM_LO  = 2;
    localparam int REG_EN_PWM_HI  = 3;
    localparam int REG_PWM_DUTY   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPI_WR = 2'd1,
        ST_LOC_WR = 2'd2
    } state_e;

    typedef enum logic {
        SRC_SPI = 1'b0,
        SRC_LOC = 1'b1
    } src_e;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small synchronous FIFO for queued SPI writes; the head is visible combinationally on rdata_o.
// No internal backpressure: the caller only pushes when there is room (or a pop happens in the same cycle) and only pops when the FIFO is non-empty.
module reg_wr_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_write_scheduler.sv
// Owns the five config registers and arbitrates SPI (queued) and local (req/ack) writes round-robin.
// Two clocks per commit; local master is stalled by withholding loc_ack, SPI frames are dropped with spi_ovf when the queue is full.
module reg_write_scheduler
    import reg_write_scheduler_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_valid,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_data,
    output logic              spi_ovf,
    input  logic              loc_req,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_data,
    output logic              loc_ack,
    output logic              addr_err,
    output logic              busy,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle
);

    localparam int EW = ADDR_W + DATA_W;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_head;

    state_e            state_q;
    src_e              last_grant_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              spi_ovf_q;

    logic              grant_spi;
    logic              grant_loc;

    // On a tie the source that did not win last time gets the slot.
    always_comb begin
        grant_spi = 1'b0;
        grant_loc = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!fifo_empty && (!loc_req || last_grant_q == SRC_LOC)) begin
                grant_spi = 1'b1;
            end else if (loc_req) begin
                grant_loc = 1'b1;
            end
        end
    end

    assign fifo_pop  = grant_spi;
    assign fifo_push = spi_valid && (!fifo_full || fifo_pop);

    reg_wr_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({spi_addr, spi_data}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_LOC;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            spi_ovf_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            spi_ovf_q <= spi_valid && !fifo_push;
            case (state_q)
                ST_IDLE: begin
                    if (grant_spi) begin
                        wr_addr_q    <= fifo_head[EW-1:DATA_W];
                        wr_data_q    <= fifo_head[DATA_W-1:0];
                        last_grant_q <= SRC_SPI;
                        state_q      <= ST_SPI_WR;
                    end else if (grant_loc) begin
                        wr_addr_q    <= loc_addr;
                        wr_data_q    <= loc_data;
                        last_grant_q <= SRC_LOC;
                        state_q      <= ST_LOC_WR;
                    end
                end
                ST_SPI_WR, ST_LOC_WR: begin
                    case (wr_addr_q)
                        ADDR_W'(REG_EN_OUT_LO): regs_q[REG_EN_OUT_LO] <= wr_data_q;
                        ADDR_W'(REG_EN_OUT_HI): regs_q[REG_EN_OUT_HI] <= wr_data_q;
                        ADDR_W'(REG_EN_PWM_LO): regs_q[REG_EN_PWM_LO] <= wr_data_q;
                        ADDR_W'(REG_EN_PWM_HI): regs_q[REG_EN_PWM_HI] <= wr_data_q;
                        ADDR_W'(REG_PWM_DUTY):  regs_q[REG_PWM_DUTY]  <= wr_data_q;
                        default: ;
                    endcase
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign loc_ack  = (state_q == ST_LOC_WR);
    assign addr_err = (state_q != ST_IDLE) && (wr_addr_q >= ADDR_W'(NUM_REGS));
    assign spi_ovf  = spi_ovf_q;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);

    assign en_reg_out_7_0  = regs_q[REG_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[REG_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[REG_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[REG_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[REG_PWM_DUTY];

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Randomised and directed bench for reg_write_scheduler against a queue-based write-slot model.
// Every cycle the DUT outputs are compared with the model at the falling edge.
module tb_reg_write_scheduler;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spi_valid = 1'b0;
    logic [ADDR_W-1:0] spi_addr = '0;
    logic [DATA_W-1:0] spi_data = '0;
    logic              spi_ovf;
    logic              loc_req = 1'b0;
    logic [ADDR_W-1:0] loc_addr = '0;
    logic [DATA_W-1:0] loc_data = '0;
    logic              loc_ack;
    logic              addr_err;
    logic              busy;
    logic [DATA_W-1:0] en_reg_out_7_0;
    logic [DATA_W-1:0] en_reg_out_15_8;
    logic [DATA_W-1:0] en_reg_pwm_7_0;
    logic [DATA_W-1:0] en_reg_pwm_15_8;
    logic [DATA_W-1:0] pwm_duty_cycle;

    reg_write_scheduler #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_valid       (spi_valid),
        .spi_addr        (spi_addr),
        .spi_data        (spi_data),
        .spi_ovf         (spi_ovf),
        .loc_req         (loc_req),
        .loc_addr        (loc_addr),
        .loc_data        (loc_data),
        .loc_ack         (loc_ack),
        .addr_err        (addr_err),
        .busy            (busy),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: pending SPI frames as a bounded queue, one write slot
    // that is either empty or holds the write to be committed on the next edge.
    logic [7:0]  m_regs [5];
    logic [14:0] m_q [$];
    bit          m_slot_full;
    bit          m_slot_loc;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    bit          m_last_loc;
    bit          m_ovf;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        m_q.delete();
        m_slot_full = 0;
        m_slot_loc  = 0;
        m_addr      = '0;
        m_data      = '0;
        m_last_loc  = 1;
        m_ovf       = 0;
    endtask

    task automatic model_step();
        logic [14:0] head;
        if (m_slot_full) begin
            if (m_addr < 7'd5) m_regs[m_addr] = m_data;
            m_slot_full = 0;
        end else if (m_q.size() > 0 && (!loc_req || m_last_loc)) begin
            head        = m_q.pop_front();
            m_addr      = head[14:8];
            m_data      = head[7:0];
            m_slot_full = 1;
            m_slot_loc  = 0;
            m_last_loc  = 0;
        end else if (loc_req) begin
            m_addr      = loc_addr;
            m_data      = loc_data;
            m_slot_full = 1;
            m_slot_loc  = 1;
            m_last_loc  = 1;
        end
        m_ovf = 0;
        if (spi_valid) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back({spi_addr, spi_data});
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check_val("en_reg_out_7_0",  en_reg_out_7_0,  m_regs[0]);
        check_val("en_reg_out_15_8", en_reg_out_15_8, m_regs[1]);
        check_val("en_reg_pwm_7_0",  en_reg_pwm_7_0,  m_regs[2]);
        check_val("en_reg_pwm_15_8", en_reg_pwm_15_8, m_regs[3]);
        check_val("pwm_duty_cycle",  pwm_duty_cycle,  m_regs[4]);
        check_val("loc_ack",  loc_ack,  m_slot_full && m_slot_loc);
        check_val("addr_err", addr_err, m_slot_full && (m_addr > 7'd4));
        check_val("spi_ovf",  spi_ovf,  m_ovf);
        check_val("busy",     busy,     (m_q.size() > 0) || m_slot_full);
    endtask

    int  ack_cnt = 0;
    int  ovf_cnt = 0;
    int  err_cnt = 0;
    bit  ack_seen;

    // One clock: compare, advance model on the edge, then release pulses and
    // let the local master drop its request after an observed ack.
    task automatic step();
        @(negedge clk);
        compare_all();
        ack_seen = loc_ack;
        if (loc_ack)  ack_cnt++;
        if (spi_ovf)  ovf_cnt++;
        if (addr_err) err_cnt++;
        @(posedge clk);
        model_step();
        #1;
        spi_valid = 1'b0;
        if (ack_seen) loc_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        spi_valid = 1'b0;
        loc_req   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic spi_pulse(input logic [6:0] a, input logic [7:0] d);
        spi_valid = 1'b1;
        spi_addr  = a;
        spi_data  = d;
    endtask

    task automatic loc_raise(input logic [6:0] a, input logic [7:0] d);
        loc_req  = 1'b1;
        loc_addr = a;
        loc_data = d;
    endtask

    initial begin
        do_reset();
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_duty", pwm_duty_cycle, 8'h00);

        // Single SPI write: visible after the second edge following the push.
        spi_pulse(7'h04, 8'h80);
        step();
        step();
        check_val("spi_lat_early", pwm_duty_cycle, 8'h00);
        step();
        check_val("spi_lat_commit", pwm_duty_cycle, 8'h80);
        repeat (2) step();

        // Local write: exactly one ack, no repeat write after the drop.
        ack_cnt = 0;
        loc_raise(7'h02, 8'hA5);
        repeat (6) step();
        check_val("loc_ack_count", ack_cnt, 1);
        check_val("loc_write", en_reg_pwm_7_0, 8'hA5);

        // Invalid address: flagged, nothing written.
        err_cnt = 0;
        spi_pulse(7'h05, 8'hFF);
        repeat (4) step();
        check_val("addr_err_count", err_cnt, 1);
        check_val("addr_err_duty", pwm_duty_cycle, 8'h80);
        check_val("addr_err_pwm", en_reg_pwm_7_0, 8'hA5);

        // Contested slot after reset: SPI wins the first tie, local follows.
        do_reset();
        spi_pulse(7'h00, 8'h11);
        step();
        loc_raise(7'h00, 8'h22);
        step();
        step();
        check_val("tie_spi_first", en_reg_out_7_0, 8'h11);
        step();
        step();
        check_val("tie_loc_second", en_reg_out_7_0, 8'h22);
        for (int k = 0; k < 4; k++) begin
            spi_pulse(7'h01, 8'h50 + 8'(k));
            if (!loc_req) loc_raise(7'h01, 8'h60 + 8'(k));
            step();
            step();
        end
        repeat (6) step();
        check_val("alt_final_busy", busy, 1'b0);

        // Overflow: three back-to-back frames while the local master owns a slot.
        do_reset();
        ovf_cnt = 0;
        spi_pulse(7'h03, 8'h30);
        step();
        loc_raise(7'h02, 8'h44);
        spi_pulse(7'h00, 8'h31);
        step();
        spi_pulse(7'h01, 8'h32);
        step();
        spi_pulse(7'h03, 8'h33);
        step();
        repeat (8) step();
        check_val("ovf_count", ovf_cnt, 1);
        check_val("ovf_first",  en_reg_out_7_0,  8'h31);
        check_val("ovf_second", en_reg_out_15_8, 8'h32);
        check_val("ovf_dropped", en_reg_pwm_15_8, 8'h30);
        check_val("ovf_local",  en_reg_pwm_7_0,  8'h44);

        // Reset while a local write is in flight.
        loc_raise(7'h02, 8'h5A);
        step();
        check_val("inflight_ack", loc_ack, 1'b1);
        rst_n   = 1'b0;
        loc_req = 1'b0;
        model_reset();
        #1;
        check_val("rst_mid_ack", loc_ack, 1'b0);
        check_val("rst_mid_reg", en_reg_pwm_7_0, 8'h00);
        check_val("rst_mid_out", en_reg_out_7_0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        ack_cnt = 0;
        repeat (3) step();
        check_val("rst_mid_noack", ack_cnt, 0);
        check_val("rst_mid_idle", busy, 1'b0);

        // Random traffic from both requesters.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int a;
                a = $urandom_range(0, 7);
                if (a == 7) a = $urandom_range(5, 127);
                spi_pulse(7'(a), 8'($urandom_range(0, 255)));
            end
            if (!loc_req && $urandom_range(0, 3) == 0) begin
                int a;
                a = $urandom_range(0, 6);
                loc_raise(7'(a), 8'($urandom_range(0, 255)));
            end
            step();
        end
        loc_req = 1'b0;
        repeat (8) step();
        check_val("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_scheduler.md
# reg_write_scheduler

Owns the five 8-bit configuration registers (output enables, PWM enables, PWM duty cycle) and schedules all writes to them. Two requesters share the single write path: decoded SPI write frames (fire-and-forget pulses, buffered in a small FIFO) and a local on-chip master (req/ack handshake). Round-robin arbitration, one committed write per two clocks, invalid addresses dropped and flagged.

## Interface
- ADDR_W, 7, register address width
- DATA_W, 8, register data width
- FIFO_DEPTH, 2, SPI write queue depth; power of two, ≥2

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_valid  in  1  one-cycle pulse: decoded SPI write frame ready
- spi_addr  in  ADDR_W  SPI write address
- spi_data  in  DATA_W  SPI write data
- spi_ovf  out  1  one-cycle pulse: SPI frame dropped, queue full
- loc_req  in  1  local write request, held until loc_ack
- loc_addr  in  ADDR_W  local write address, stable while loc_req
- loc_data  in  DATA_W  local write data, stable while loc_req
- loc_ack  out  1  one-cycle pulse: local write committed
- addr_err  out  1  one-cycle pulse: committed address > 4, write discarded
- busy  out  1  queue non-empty or FSM not IDLE
- en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  out  DATA_W each  register map, addresses 0x00..0x04

## Operation
- FSM states: IDLE, SPI_WR, LOC_WR.
- IDLE: spi_pend = queue non-empty; loc_pend = loc_req. Neither → stay. One → grant it. Both → grant the one not in last_grant. Grant latches addr/data into wr_addr/wr_data, updates last_grant, moves to SPI_WR or LOC_WR.
- SPI grant pops the queue head in the same cycle.
- SPI_WR / LOC_WR: commit wr_data to the register at wr_addr on the exiting edge. Always return to IDLE. Addresses 5..127 write nothing and pulse addr_err.
- loc_ack = (state == LOC_WR), Moore. The local master deasserts loc_req on the edge where it samples loc_ack high.
- Queue: push when spi_valid is high and the queue is not full, or when full and a pop happens in the same cycle. Otherwise drop and pulse spi_ovf. Push and pop may occur together. Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Reset (async, any state): all registers = 0x00; queue emptied; FSM = IDLE; last_grant = LOC, so SPI wins the first tie. loc_ack, spi_ovf, addr_err, busy = 0. In-flight writes are lost, and no ack is issued for them.

## Timing
- SPI path: spi_valid sampled at edge N → queued at N. Granted at N+1 if uncontested. Register output shows the new value after edge N+2.
- Local path: loc_req sampled at edge M (IDLE, uncontested) → LOC_WR. loc_ack is high during cycle M..M+1. Register updates at edge M+1.
- Throughput: at most one commit per 2 cycles.
- Both pending continuously: grants alternate strictly, so worst-case wait is 2 cycles per competitor.
- Same address written by both: the later commit wins. No merging.

## Structure
- Shared package: register address constants (0x00..0x04), NUM_REGS = 5, FSM state enum, grant-source enum {SPI, LOC}.
- One sub-module, reg_wr_fifo, holds the parameterised synchronous FIFO with full/empty flags and async reset.
- The FSM, arbiter and register file live in the top module.

## Test plan
- Reset then idle → all five outputs 0x00; busy=0, loc_ack=0.
- Single SPI write addr 0x04 data 0x80 → pwm_duty_cycle=0x80 two edges after the spi_valid edge; no loc_ack.
- Local write addr 0x02 data 0xA5, loc_req held → loc_ack exactly one cycle; en_reg_pwm_7_0=0xA5; loc_req dropped after ack → no second write.
- SPI and local pending together, both addr 0x00: SPI 0x11, local 0x22 → SPI committed first (reset tie-break), then local; final en_reg_out_7_0=0x22; grants alternate over 4 more contested pairs.
- Three spi_valid pulses on consecutive cycles while local traffic holds the bus, FIFO_DEPTH=2 → third pulse gives spi_ovf; first two commit in order.
- Write to addr 0x05 → addr_err pulse, all registers unchanged. Assert rst_n low mid-LOC_WR → registers 0x00, no loc_ack, FSM IDLE after release.
